// File: rtl/ov5640_init_seq_if.sv
// Bundle between the OV5640 init sequencer, its register-table ROM and the
// I2C byte-writer. The sequencer is the master side.
interface ov5640_init_seq_if #(
  parameter int IDX_W = 8
);
  logic [IDX_W-1:0] rom_addr;
  logic [23:0]      rom_data;
  logic [23:0]      wr_dat;
  logic             wr_start;
  logic             wr_done;
  logic             wr_nack;

  modport master (
    output rom_addr, wr_dat, wr_start,
    input  rom_data, wr_done, wr_nack
  );

  modport slave (
    input  rom_addr, wr_dat, wr_start,
    output rom_data, wr_done, wr_nack
  );
endinterface

// File: rtl/ov5640_init_seq.sv
// OV5640 register-initialisation sequencer: waits out sensor power-up, then
// walks a {reg_addr, reg_val} table in an external synchronous ROM and issues
// one I2C write per entry, honouring delay entries, an end marker and a
// bounded NACK retry.
module ov5640_init_seq #(
  parameter int NUM_ENTRIES = 256,
  parameter int IDX_W       = 8,
  parameter int PWR_DLY     = 500000,
  parameter int GAP_CYCLES  = 125,
  parameter int DLY_UNIT    = 25000,
  parameter int MAX_RETRY   = 3
) (
  input  logic              meg25,
  input  logic              reset,
  input  logic              start,
  ov5640_init_seq_if.master bus,
  output logic              init_done,
  output logic              init_err,
  output logic [IDX_W-1:0]  cur_index
);

  // One shared counter serves power-up, inter-write gap and delay entries;
  // it must hold the largest of them (a 254-unit delay at most).
  localparam int DLY_MAX = 254 * DLY_UNIT;
  localparam int PG_MAX  = (PWR_DLY > GAP_CYCLES) ? PWR_DLY : GAP_CYCLES;
  localparam int CNT_MAX = (PG_MAX > DLY_MAX) ? PG_MAX : DLY_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    S_PWRUP, S_IDLE, S_FETCH, S_DECODE, S_ISSUE,
    S_WAIT_WR, S_GAP, S_DELAY, S_FIN, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [RTY_W-1:0] retry_q;
  logic [23:0]      wr_dat_q;

  logic is_end, is_dly, is_last, pwr_end, gap_end, dly_end;
  logic retrying, can_retry;

  // End marker wins over the delay pattern, so FFFFFF is never a delay.
  assign is_end    = (bus.rom_data == 24'hFFFFFF);
  assign is_dly    = (bus.rom_data[23:8] == 16'hFFFF) && !is_end;
  assign is_last   = (idx_q == IDX_W'(NUM_ENTRIES - 1));
  assign pwr_end   = (cnt_q == CNT_W'(PWR_DLY - 1));
  assign gap_end   = (cnt_q == CNT_W'(GAP_CYCLES - 1));
  assign dly_end   = (cnt_q == '0);
  assign retrying  = (retry_q != '0);
  assign can_retry = (retry_q < RTY_W'(MAX_RETRY));

  // The table index is the ROM address and the reported progress index.
  assign bus.rom_addr = idx_q;
  assign bus.wr_dat   = wr_dat_q;
  assign cur_index    = idx_q;

  // State register; any reset restarts the power-up wait.
  always_ff @(posedge meg25 or negedge reset) begin
    if (!reset) state_q <= S_PWRUP;
    else        state_q <= state_d;
  end

  // Next-state decode; wr_start is a pure state decode so reset drops it at once.
  always_comb begin
    state_d      = state_q;
    bus.wr_start = 1'b0;
    case (state_q)
      S_PWRUP:   if (pwr_end) state_d = S_IDLE;
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        if (is_end)      state_d = S_FIN;
        else if (is_dly) state_d = S_DELAY;
        else             state_d = S_ISSUE;
      end
      S_ISSUE: begin
        bus.wr_start = 1'b1;
        state_d      = S_WAIT_WR;
      end
      S_WAIT_WR: begin
        if (bus.wr_done) begin
          if (!bus.wr_nack || can_retry) state_d = S_GAP;
          else                           state_d = S_ERR;
        end
      end
      S_GAP: begin
        if (gap_end) begin
          if (retrying)     state_d = S_ISSUE;
          else if (is_last) state_d = S_FIN;
          else              state_d = S_FETCH;
        end
      end
      S_DELAY: begin
        if (dly_end) begin
          if (is_last) state_d = S_FIN;
          else         state_d = S_FETCH;
        end
      end
      S_FIN:   state_d = S_IDLE;
      // Leaving on start low means the next rising start is seen in IDLE.
      S_ERR:   if (!start) state_d = S_IDLE;
      default: state_d = S_PWRUP;
    endcase
  end

  // Counter, table index, latched entry, retry count and status flags.
  always_ff @(posedge meg25 or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      wr_dat_q  <= '0;
      init_done <= 1'b0;
      init_err  <= 1'b0;
    end else begin
      case (state_q)
        S_PWRUP: cnt_q <= pwr_end ? '0 : cnt_q + CNT_W'(1);
        S_IDLE: begin
          if (start) begin
            idx_q     <= '0;
            retry_q   <= '0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
          end
        end
        S_DECODE: begin
          cnt_q <= is_dly ? CNT_W'(bus.rom_data[7:0]) * CNT_W'(DLY_UNIT) : '0;
          if (!is_end && !is_dly) wr_dat_q <= bus.rom_data;
        end
        S_WAIT_WR: begin
          cnt_q <= '0;
          if (bus.wr_done) begin
            if (!bus.wr_nack) retry_q  <= '0;
            else if (can_retry) retry_q <= retry_q + RTY_W'(1);
            else                init_err <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_end) begin
            cnt_q <= '0;
            if (!retrying && !is_last) idx_q <= idx_q + IDX_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DELAY: begin
          if (dly_end) begin
            if (!is_last) idx_q <= idx_q + IDX_W'(1);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_FIN: init_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ov5640_init_seq.sv
// Bench for ov5640_init_seq: ROM and I2C-writer models around the DUT, with a
// cycle-timeline reference model of the table walk.
module tb_ov5640_init_seq;

  localparam int NUM_ENTRIES = 4;
  localparam int IDX_W       = 2;
  localparam int PWR_DLY     = 10;
  localparam int GAP_CYCLES  = 4;
  localparam int DLY_UNIT    = 8;
  localparam int MAX_RETRY   = 2;

  typedef struct {
    int          start_cyc;
    logic [23:0] dat;
    int          done_cyc;
    bit          nack;
  } tr_t;

  logic             meg25;
  logic             reset;
  logic             start;
  logic             init_done;
  logic             init_err;
  logic [IDX_W-1:0] cur_index;

  ov5640_init_seq_if #(.IDX_W(IDX_W)) bus ();

  ov5640_init_seq #(
    .NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W), .PWR_DLY(PWR_DLY),
    .GAP_CYCLES(GAP_CYCLES), .DLY_UNIT(DLY_UNIT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .meg25(meg25), .reset(reset), .start(start), .bus(bus),
    .init_done(init_done), .init_err(init_err), .cur_index(cur_index)
  );

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_starts = 0;
  int          nack_pct, nack_left, wr_lat_fix;
  logic [23:0] nack_val;
  logic [23:0] rom [4];
  tr_t         log_q[$];

  initial begin
    meg25 = 1'b0;
    forever #5 meg25 = ~meg25;
  end

  always @(posedge meg25) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchronous ROM: data for an address appears one cycle after it is presented.
  initial begin
    logic [IDX_W-1:0] prev;
    prev = '0;
    bus.rom_data = '0;
    forever begin
      @(negedge meg25);
      bus.rom_data = rom[prev];
      prev = bus.rom_addr;
    end
  end

  // I2C writer: random latency, NACKs chosen by a directed plan or at random.
  initial begin
    tr_t tr;
    int  lat;
    bit  nk;
    bus.wr_done = 1'b0;
    bus.wr_nack = 1'b0;
    forever begin
      @(negedge meg25);
      if (bus.wr_start === 1'b1) begin
        n_starts++;
        tr.start_cyc = cyc;
        tr.dat = bus.wr_dat;
        lat = (wr_lat_fix > 0) ? wr_lat_fix : int'($urandom_range(1, 5));
        repeat (lat) @(negedge meg25);
        nk = 1'b0;
        if (tr.dat == nack_val && nack_left > 0) begin
          nk = 1'b1;
          nack_left--;
        end else if (int'($urandom_range(0, 99)) < nack_pct) begin
          nk = 1'b1;
        end
        if (reset) chk("wr_dat held until done", 32'(bus.wr_dat), 32'(tr.dat));
        bus.wr_done = 1'b1;
        bus.wr_nack = nk;
        tr.done_cyc = cyc;
        tr.nack = nk;
        log_q.push_back(tr);
        @(negedge meg25);
        bus.wr_done = 1'b0;
        bus.wr_nack = 1'b0;
      end
    end
  end

  // Timeline model: from the start cycle and the writer's done events, derive
  // when each write must begin, what it carries, and how the run must end.
  task automatic check_run(input string tag, input int s, input int fin);
    int          pos, idx, k, retry, issue, exp_fin;
    bit          exp_err, stop, wdone;
    logic [23:0] e;
    pos = s; idx = 0; k = 0; exp_err = 0; exp_fin = -1; stop = 0;
    while (!stop) begin
      e = rom[idx];
      if (e == 24'hFFFFFF) begin
        exp_fin = pos + 4;
        stop = 1;
      end else begin
        if (e[23:8] == 16'hFFFF) begin
          pos = pos + 3 + int'(e[7:0]) * DLY_UNIT;
        end else begin
          issue = pos + 3; retry = 0; wdone = 0;
          while (!wdone) begin
            if (k >= log_q.size()) begin
              chk({tag, " writes present"}, 32'(log_q.size()), 32'(k + 1));
              wdone = 1; stop = 1;
            end else begin
              chk({tag, " wr_start cycle"}, 32'(log_q[k].start_cyc), 32'(issue));
              chk({tag, " wr_dat"}, 32'(log_q[k].dat), 32'(e));
              if (log_q[k].nack && retry < MAX_RETRY) begin
                retry++;
                issue = log_q[k].done_cyc + GAP_CYCLES + 1;
              end else if (log_q[k].nack) begin
                exp_err = 1; exp_fin = log_q[k].done_cyc + 1;
                wdone = 1; stop = 1;
              end else begin
                pos = log_q[k].done_cyc + GAP_CYCLES;
                wdone = 1;
              end
              k++;
            end
          end
        end
        if (!stop) begin
          if (idx == NUM_ENTRIES - 1) begin
            exp_fin = pos + 2;
            stop = 1;
          end else begin
            idx++;
          end
        end
      end
    end
    chk({tag, " write count"}, 32'(log_q.size()), 32'(k));
    chk({tag, " finish cycle"}, 32'(fin), 32'(exp_fin));
    chk({tag, " init_done"}, 32'(init_done), 32'(!exp_err));
    chk({tag, " init_err"}, 32'(init_err), 32'(exp_err));
    chk({tag, " cur_index"}, 32'(cur_index), 32'(idx));
  endtask

  task automatic wait_fin(input int s, output bit got, output int fin);
    got = 0; fin = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge meg25);
      if (cyc > s + 1 && (init_done === 1'b1 || init_err === 1'b1)) begin
        got = 1; fin = cyc;
        break;
      end
    end
  endtask

  task automatic run_seq(input string tag);
    int s, fin;
    bit got;
    repeat (3) @(negedge meg25);
    log_q.delete();
    start = 1'b1;
    s = cyc;
    @(negedge meg25);
    start = 1'b0;
    wait_fin(s, got, fin);
    chk({tag, " finished in time"}, 32'(got), 32'(1));
    if (got) check_run(tag, s, fin);
  endtask

  task automatic rand_table();
    int r;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      rom[i] = 24'hFFFFFF;
      else if (r <= 2) rom[i] = {16'hFFFF, 8'($urandom_range(0, 3))};
      else             rom[i] = {1'b0, 15'($urandom), 8'($urandom)};
    end
  endtask

  initial begin
    int rel, first, fin, cnt;
    bit got;
    reset = 1'b0; start = 1'b0;
    nack_pct = 0; nack_left = 0; nack_val = '0; wr_lat_fix = 0;
    rom = '{24'h300842, 24'h310303, 24'hFFFF02, 24'h30341A};
    repeat (3) @(negedge meg25);
    chk("reset rom_addr", 32'(bus.rom_addr), 32'(0));
    chk("reset wr_dat", 32'(bus.wr_dat), 32'(0));
    chk("reset wr_start", 32'(bus.wr_start), 32'(0));
    chk("reset init_done", 32'(init_done), 32'(0));
    chk("reset init_err", 32'(init_err), 32'(0));
    chk("reset cur_index", 32'(cur_index), 32'(0));

    reset = 1'b1;
    repeat (PWR_DLY + 3) @(negedge meg25);
    chk("no write before start", 32'(n_starts), 32'(0));

    // Basic table with one 2-unit delay entry.
    run_seq("table");
    chk("table: three writes", 32'(log_q.size()), 32'(3));
    if (log_q.size() == 3)
      chk("table: delay spacing", 32'(log_q[2].start_cyc - log_q[1].done_cyc),
          32'(GAP_CYCLES + 3 + 2 * DLY_UNIT + 1 + 2));

    // Entry 1 NACKed twice, then accepted.
    nack_val = 24'h310303; nack_left = 2;
    run_seq("retry");
    cnt = 0;
    foreach (log_q[i]) if (log_q[i].dat == 24'h310303) cnt++;
    chk("retry: entry 1 attempts", 32'(cnt), 32'(3));

    // Entry 0 always NACKed: retries exhausted, then a fresh start recovers.
    nack_val = 24'h300842; nack_left = 1000;
    run_seq("error");
    chk("error: attempts", 32'(log_q.size()), 32'(MAX_RETRY + 1));
    chk("error: failing index", 32'(cur_index), 32'(0));
    nack_left = 0;
    run_seq("restart");

    // End marker in slot 1.
    rom = '{24'h300842, 24'hFFFFFF, 24'h3a1234, 24'h3a5678};
    run_seq("end marker");
    chk("end marker: one write", 32'(log_q.size()), 32'(1));

    // Reset in the middle of a write; the writer's done lands during reset,
    // and start is held high across the new power-up wait.
    rom = '{24'h300842, 24'h310303, 24'hFFFF02, 24'h30341A};
    wr_lat_fix = 8;
    repeat (3) @(negedge meg25);
    start = 1'b1;
    @(negedge meg25);
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.wr_start === 1'b1) begin got = 1; break; end
      @(negedge meg25);
    end
    chk("mid-write: reached issue", 32'(got), 32'(1));
    repeat (2) @(negedge meg25);
    reset = 1'b0;
    #1;
    chk("mid-write reset wr_start", 32'(bus.wr_start), 32'(0));
    chk("mid-write reset wr_dat", 32'(bus.wr_dat), 32'(0));
    chk("mid-write reset rom_addr", 32'(bus.rom_addr), 32'(0));
    chk("mid-write reset init_done", 32'(init_done), 32'(0));
    chk("mid-write reset init_err", 32'(init_err), 32'(0));
    chk("mid-write reset cur_index", 32'(cur_index), 32'(0));
    start = 1'b1;
    repeat (10) @(negedge meg25);
    log_q.delete();
    wr_lat_fix = 0;
    reset = 1'b1;
    rel = cyc;
    first = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge meg25);
      if (bus.wr_start === 1'b1) begin first = cyc; break; end
    end
    start = 1'b0;
    chk("held start: first wr_start", 32'(first), 32'(rel + PWR_DLY + 3));
    wait_fin(first, got, fin);
    chk("held start finished in time", 32'(got), 32'(1));
    if (got) check_run("held start", rel + PWR_DLY, fin);

    // Random tables with random NACKs and writer latencies.
    nack_pct = 25;
    for (int r = 0; r < 12; r++) begin
      rand_table();
      run_seq($sformatf("random %0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
